// File: rtl/reservation_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : reservation_unit_if
//  Description : Signal bundle between the retire/LSU side of the pipeline,
//                the external bus write-snoop port and the LR/SC reservation
//                unit. The master modport drives the event inputs and observes
//                the reservation outputs. The slave modport is the
//                reservation unit's view.
//  Signals     : stall, lr_commit_i, lr_addr_i[31:0], lr_data_i[31:0],
//                sc_done_i, store_valid_i, store_addr_i[31:0],
//                snoop_valid_i, snoop_addr_i[31:0], trap_clear_i
//                -> reservation_valid_o, reservation_addr_o[31:0],
//                   reservation_data_o[31:0], invalidate_count_o[15:0]
//  Revision    : 1.0 - initial release
// ============================================================================
interface reservation_unit_if;
  // Core-side events (frozen by stall inside the unit)
  logic        stall;
  logic        lr_commit_i;
  logic [31:0] lr_addr_i;
  logic [31:0] lr_data_i;
  logic        sc_done_i;
  logic        store_valid_i;
  logic [31:0] store_addr_i;
  logic        trap_clear_i;
  // External bus write snoop (never stalled)
  logic        snoop_valid_i;
  logic [31:0] snoop_addr_i;
  // Reservation state presented to the LR/SC execute unit
  logic        reservation_valid_o;
  logic [31:0] reservation_addr_o;
  logic [31:0] reservation_data_o;
  logic [15:0] invalidate_count_o;

  modport master (
    output stall, lr_commit_i, lr_addr_i, lr_data_i, sc_done_i,
           store_valid_i, store_addr_i, trap_clear_i,
           snoop_valid_i, snoop_addr_i,
    input  reservation_valid_o, reservation_addr_o,
           reservation_data_o, invalidate_count_o
  );

  modport slave (
    input  stall, lr_commit_i, lr_addr_i, lr_data_i, sc_done_i,
           store_valid_i, store_addr_i, trap_clear_i,
           snoop_valid_i, snoop_addr_i,
    output reservation_valid_o, reservation_addr_o,
           reservation_data_o, invalidate_count_o
  );
endinterface : reservation_unit_if
`default_nettype wire

// File: rtl/reservation_unit.sv
`default_nettype none
// ============================================================================
//  Module      : reservation_unit
//  Description : Single-hart LR/SC reservation register. It holds the granule
//                address and the word loaded by the last committed LR.W and
//                feeds both to the LR/SC execute unit.
//                - Set by an accepted LR.
//                - Cleared by SC completion, trap entry or xRET.
//                - Invalidated by a core store or an external bus write that
//                  hits the reserved granule.
//                All outputs are registered.
//  Ports       : clk, reset_n (async, active-low)
//                bus (reservation_unit_if.slave):
//                  stall, lr_commit_i, lr_addr_i, lr_data_i, sc_done_i,
//                  store_valid_i, store_addr_i, snoop_valid_i, snoop_addr_i,
//                  trap_clear_i -> reservation_valid_o, reservation_addr_o,
//                  reservation_data_o, invalidate_count_o
//  Parameters  : GRANULE_LOG2   - log2 of the granule in bytes (2..6)
//                TIMEOUT_CYCLES - reservation lifetime (1..65535), only used
//                                 when the timeout feature is built in
//  Macros      : RESERVATION_TIMEOUT_EN - builds the lifetime timer. When it is
//                undefined, a reservation lives until it is cleared or
//                invalidated.
//  Revision    : 1.0 - initial release
// ============================================================================
module reservation_unit #(
  parameter int GRANULE_LOG2   = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  wire logic        clk,
  input  wire logic        reset_n,
  reservation_unit_if.slave bus
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  // Not word-aligned, so no aligned SC address can ever match an empty unit.
  localparam logic [31:0] ADDR_INVALID = 32'hFFFF_FFFF;
  localparam logic [15:0] COUNT_MAX    = 16'hFFFF;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_VALID = 1'b1
  } state_e;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [31:0] addr_q,  addr_d;
  logic [31:0] data_q,  data_d;
  logic [15:0] count_q, count_d;

  // --------------------------------------------------------------------------
  // Event decode
  // --------------------------------------------------------------------------
  logic lr_accept_w;
  logic clear_w;
  logic snoop_hit_cur_w;
  logic snoop_hit_lr_w;
  logic store_hit_cur_w;
  logic store_hit_lr_w;
  logic snoop_inv_w;
  logic store_inv_w;
  logic timeout_w;
  logic load_w;
  logic count_inc_w;

  // Compare only the granule index bits.
  function automatic logic granule_match(input logic [31:0] a,
                                         input logic [31:0] b);
    return a[31:GRANULE_LOG2] == b[31:GRANULE_LOG2];
  endfunction

  assign lr_accept_w = bus.lr_commit_i & ~bus.stall;
  assign clear_w     = (bus.sc_done_i | bus.trap_clear_i) & ~bus.stall;

  // A write can kill either the reservation being held or the reservation
  // that an LR in this same cycle is trying to establish.
  assign snoop_hit_cur_w = (state_q == ST_VALID) &&
                           granule_match(bus.snoop_addr_i, addr_q);
  assign snoop_hit_lr_w  = lr_accept_w &&
                           granule_match(bus.snoop_addr_i, bus.lr_addr_i);
  assign store_hit_cur_w = (state_q == ST_VALID) &&
                           granule_match(bus.store_addr_i, addr_q);
  assign store_hit_lr_w  = lr_accept_w &&
                           granule_match(bus.store_addr_i, bus.lr_addr_i);

  // The snoop ignores stall because external masters keep running while the
  // core is frozen.
  assign snoop_inv_w = bus.snoop_valid_i & (snoop_hit_cur_w | snoop_hit_lr_w);
  assign store_inv_w = bus.store_valid_i & ~bus.stall &
                       (store_hit_cur_w | store_hit_lr_w);

  // Sub-granule address bits never take part in matching.
  logic w_unused_low_bits;
  assign w_unused_low_bits = ^{bus.store_addr_i[GRANULE_LOG2-1:0],
                               bus.snoop_addr_i[GRANULE_LOG2-1:0]};

  // --------------------------------------------------------------------------
  // Optional lifetime timer
  // --------------------------------------------------------------------------
`ifdef RESERVATION_TIMEOUT_EN
  localparam logic [15:0] TIMER_LOAD = 16'(TIMEOUT_CYCLES);

  logic [15:0] timer_q, timer_d;

  // The timer expires when it would step from 1 to 0. This makes the
  // reservation visible for exactly TIMEOUT_CYCLES cycles after the LR.
  assign timeout_w = (state_q == ST_VALID) && (timer_q == 16'd1);

  always_comb begin
    timer_d = 16'd0;
    if (state_d == ST_VALID) begin
      if (load_w) begin
        timer_d = TIMER_LOAD;
      end else if (timer_q != 16'd0) begin
        timer_d = timer_q - 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer_q <= 16'd0;
    end else begin
      timer_q <= timer_d;
    end
  end
`else
  logic [15:0] w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = 16'(TIMEOUT_CYCLES);
  assign timeout_w            = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Next-state / output-register logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    load_w      = 1'b0;
    count_inc_w = 1'b0;

    if (clear_w) begin
      // SC completion or trap/xRET also drops an LR accepted in this cycle.
      state_d = ST_EMPTY;
    end else if (snoop_inv_w || store_inv_w) begin
      state_d     = ST_EMPTY;
      count_inc_w = 1'b1;
    end else if (lr_accept_w) begin
      state_d = ST_VALID;
      load_w  = 1'b1;
    end else if (timeout_w) begin
      state_d     = ST_EMPTY;
      count_inc_w = 1'b1;
    end

    if (load_w) begin
      addr_d = bus.lr_addr_i;
      data_d = bus.lr_data_i;
    end else if (state_d == ST_EMPTY) begin
      addr_d = ADDR_INVALID;
      data_d = 32'd0;
    end

    count_d = count_q;
    if (count_inc_w && (count_q != COUNT_MAX)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_EMPTY;
      addr_q  <= ADDR_INVALID;
      data_q  <= 32'd0;
      count_q <= 16'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs (straight from registers)
  // --------------------------------------------------------------------------
  assign bus.reservation_valid_o = (state_q == ST_VALID);
  assign bus.reservation_addr_o  = addr_q;
  assign bus.reservation_data_o  = data_q;
  assign bus.invalidate_count_o  = count_q;

endmodule : reservation_unit
`default_nettype wire

// File: tb/tb_reservation_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reservation_unit
//  Description : Self-checking bench for reservation_unit. A vector table
//                applies one cycle per record and checks the registered
//                outputs after the edge. Hand sequences then cover the
//                lifetime/persistence behaviour, counter saturation and
//                asynchronous reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reservation_unit;

  localparam int TO_CYCLES = 4;
  localparam logic [31:0] INV = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  reservation_unit_if rif ();

  reservation_unit #(
    .GRANULE_LOG2   (2),
    .TIMEOUT_CYCLES (TO_CYCLES)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (rif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        lr;
    logic [31:0] lr_addr;
    logic [31:0] lr_data;
    logic        sc;
    logic        st;
    logic [31:0] st_addr;
    logic        sn;
    logic [31:0] sn_addr;
    logic        trap;
    logic        exp_v;
    logic [31:0] exp_a;
    logic [31:0] exp_d;
    logic [15:0] exp_c;
  } vec_t;

  localparam int NVEC = 29;
  vec_t tbl [NVEC];

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_cnt;

  function automatic vec_t mk(input logic stall, input logic lr,
                              input logic [31:0] la, input logic [31:0] ld,
                              input logic sc, input logic st,
                              input logic [31:0] sa, input logic sn,
                              input logic [31:0] na, input logic trap,
                              input logic ev, input logic [31:0] ea,
                              input logic [31:0] ed, input logic [15:0] ec);
    vec_t v;
    v.stall = stall; v.lr = lr; v.lr_addr = la; v.lr_data = ld;
    v.sc = sc; v.st = st; v.st_addr = sa; v.sn = sn; v.sn_addr = na;
    v.trap = trap; v.exp_v = ev; v.exp_a = ea; v.exp_d = ed; v.exp_c = ec;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rif.stall         = v.stall;
    rif.lr_commit_i   = v.lr;
    rif.lr_addr_i     = v.lr_addr;
    rif.lr_data_i     = v.lr_data;
    rif.sc_done_i     = v.sc;
    rif.store_valid_i = v.st;
    rif.store_addr_i  = v.st_addr;
    rif.snoop_valid_i = v.sn;
    rif.snoop_addr_i  = v.sn_addr;
    rif.trap_clear_i  = v.trap;
  endtask

  task automatic idle_inputs();
    drive(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0));
  endtask

  task automatic check(input string name, input logic ev,
                       input logic [31:0] ea, input logic [31:0] ed,
                       input logic [15:0] ec);
    n_vec++;
    if (rif.reservation_valid_o !== ev || rif.reservation_addr_o !== ea ||
        rif.reservation_data_o !== ed || rif.invalidate_count_o !== ec) begin
      n_err++;
      $display("FAIL %s: got v=%0b a=%h d=%h c=%h, want v=%0b a=%h d=%h c=%h",
               name, rif.reservation_valid_o, rif.reservation_addr_o,
               rif.reservation_data_o, rif.invalidate_count_o,
               ev, ea, ed, ec);
    end
  endtask

  // One clock: inputs are already driven; sample 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_lr(input logic [31:0] a, input logic [31:0] d);
    drive(mk(0,1,a,d,0,0,0,0,0,0, 0,0,0,0));
    step();
  endtask

  task automatic do_idle();
    idle_inputs();
    step();
  endtask

  initial begin
    // stall lr  lr_addr       lr_data       sc st st_addr      sn sn_addr     trp  v  exp_a         exp_d         cnt
    tbl[0]  = mk(0,1,32'h0000_1004,32'hDEAD_BEEF,0,0,0,           0,0,           0, 1,32'h0000_1004,32'hDEAD_BEEF,0);
    tbl[1]  = mk(0,0,0,            0,            0,0,0,           0,0,           0, 1,32'h0000_1004,32'hDEAD_BEEF,0);
    tbl[2]  = mk(0,0,0,            0,            0,0,0,           0,0,           0, 1,32'h0000_1004,32'hDEAD_BEEF,0);
    tbl[3]  = mk(0,0,0,            0,            0,0,0,           0,0,           0, 1,32'h0000_1004,32'hDEAD_BEEF,0);
    tbl[4]  = mk(0,1,32'h0000_1004,32'h1234_5678,0,0,0,           0,0,           0, 1,32'h0000_1004,32'h1234_5678,0);
    tbl[5]  = mk(0,0,0,            0,            0,1,32'h0000_1008,0,0,           0, 1,32'h0000_1004,32'h1234_5678,0);
    tbl[6]  = mk(0,0,0,            0,            0,1,32'h0000_1006,0,0,           0, 0,INV,          0,            1);
    tbl[7]  = mk(0,0,0,            0,            0,1,32'h0000_1004,0,0,           0, 0,INV,          0,            1);
    tbl[8]  = mk(0,1,32'h0000_2000,32'hA5A5_A5A5,0,0,0,           0,0,           0, 1,32'h0000_2000,32'hA5A5_A5A5,1);
    tbl[9]  = mk(1,1,32'h0000_2100,32'h0000_0BAD,1,0,0,           0,0,           0, 1,32'h0000_2000,32'hA5A5_A5A5,1);
    tbl[10] = mk(1,0,0,            0,            0,1,32'h0000_2000,0,0,           0, 1,32'h0000_2000,32'hA5A5_A5A5,1);
    tbl[11] = mk(1,0,0,            0,            0,0,0,           1,32'h0000_2000,0, 0,INV,          0,            2);
    tbl[12] = mk(0,1,32'h0000_3000,32'h0000_0011,0,0,0,           1,32'h0000_3000,0, 0,INV,          0,            3);
    tbl[13] = mk(0,1,32'h0000_3000,32'h0000_0011,1,0,0,           0,0,           0, 0,INV,          0,            3);
    tbl[14] = mk(0,1,32'h0000_3000,32'h0000_0022,0,0,0,           0,0,           0, 1,32'h0000_3000,32'h0000_0022,3);
    tbl[15] = mk(0,0,0,            0,            0,0,0,           1,32'h0000_3003,0, 0,INV,          0,            4);
    tbl[16] = mk(0,1,32'h0000_4000,32'h0000_0033,0,0,0,           0,0,           0, 1,32'h0000_4000,32'h0000_0033,4);
    tbl[17] = mk(0,0,0,            0,            0,0,0,           0,0,           1, 0,INV,          0,            4);
    tbl[18] = mk(0,1,32'h0000_5000,32'h0000_0044,0,0,0,           0,0,           0, 1,32'h0000_5000,32'h0000_0044,4);
    tbl[19] = mk(0,0,0,            0,            0,0,0,           1,32'h0000_5004,0, 1,32'h0000_5000,32'h0000_0044,4);
    tbl[20] = mk(0,1,32'h0000_6000,32'h0000_0055,0,0,0,           1,32'h0000_5000,0, 0,INV,          0,            5);
    tbl[21] = mk(0,1,32'h0000_7000,32'h0000_0066,0,1,32'h0000_7001,0,0,           0, 0,INV,          0,            6);
    tbl[22] = mk(0,1,32'h0000_8000,32'h0000_0077,1,0,0,           1,32'h0000_8000,0, 0,INV,          0,            6);
    tbl[23] = mk(0,1,32'h0000_9000,32'h0000_0088,0,0,0,           0,0,           0, 1,32'h0000_9000,32'h0000_0088,6);
    tbl[24] = mk(0,1,32'h0000_9100,32'h0000_0099,0,1,32'h0000_9000,0,0,           0, 0,INV,          0,            7);
    tbl[25] = mk(0,1,32'h0000_A000,32'h0000_0001,0,0,0,           0,0,           0, 1,32'h0000_A000,32'h0000_0001,7);
    tbl[26] = mk(1,0,0,            0,            0,0,0,           0,0,           1, 1,32'h0000_A000,32'h0000_0001,7);
    tbl[27] = mk(0,1,32'h0000_A004,32'h0000_0002,0,0,0,           0,0,           0, 1,32'h0000_A004,32'h0000_0002,7);
    tbl[28] = mk(0,0,0,            0,            1,0,0,           0,0,           0, 0,INV,          0,            7);

    idle_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", 0, INV, 0, 0);
    reset_n = 1'b1;
    step();
    check("after_reset_idle", 0, INV, 0, 0);

    for (int i = 0; i < NVEC; i++) begin
      drive(tbl[i]);
      step();
      check($sformatf("vec%0d", i), tbl[i].exp_v, tbl[i].exp_a,
            tbl[i].exp_d, tbl[i].exp_c);
    end
    exp_cnt = 16'd7;

`ifdef RESERVATION_TIMEOUT_EN
    // The LR at cycle 0 stays visible for cycles 1..4 and is gone at cycle 5.
    do_lr(32'h0000_D000, 32'h0000_0005);
    check("to_c1", 1, 32'h0000_D000, 32'h5, exp_cnt);
    for (int k = 2; k <= TO_CYCLES; k++) begin
      do_idle();
      check($sformatf("to_c%0d", k), 1, 32'h0000_D000, 32'h5, exp_cnt);
    end
    do_idle();
    exp_cnt++;
    check("to_expire", 0, INV, 0, exp_cnt);
    // A new LR at cycle 3 restarts the lifetime.
    do_lr(32'h0000_D000, 32'h0000_0005);
    do_idle();
    do_idle();
    do_lr(32'h0000_D000, 32'h0000_0006);
    check("to_restart", 1, 32'h0000_D000, 32'h6, exp_cnt);
    for (int k = 1; k < TO_CYCLES; k++) begin
      do_idle();
      check($sformatf("to_rs%0d", k), 1, 32'h0000_D000, 32'h6, exp_cnt);
    end
    do_idle();
    exp_cnt++;
    check("to_rs_expire", 0, INV, 0, exp_cnt);
`else
    // Without the timer a reservation outlives any fixed number of cycles.
    do_lr(32'h0000_D000, 32'h0000_0005);
    repeat (20) do_idle();
    check("persist", 1, 32'h0000_D000, 32'h5, exp_cnt);
    drive(mk(0,0,0,0,1,0,0,0,0,0, 0,0,0,0));
    step();
    check("persist_sc", 0, INV, 0, exp_cnt);
`endif

    // Drive the counter to saturation with same-cycle LR + store hits.
    drive(mk(0,1,32'h0000_E000,32'h1,0,1,32'h0000_E000,0,0,0, 0,0,0,0));
    while (exp_cnt != 16'hFFFF) begin
      @(posedge clk);
      exp_cnt++;
    end
    #1;
    idle_inputs();
    check("sat_reach", 0, INV, 0, 16'hFFFF);
    drive(mk(0,1,32'h0000_E000,32'h1,0,0,0,1,32'h0000_E000,0, 0,0,0,0));
    step();
    check("sat_hold", 0, INV, 0, 16'hFFFF);

    // Asynchronous reset in the middle of a reservation.
    do_lr(32'h0000_F000, 32'h0000_0009);
    check("pre_reset", 1, 32'h0000_F000, 32'h9, 16'hFFFF);
    idle_inputs();
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset", 0, INV, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    check("post_reset", 0, INV, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation time limit reached, got running, want finished");
    $fatal(1);
  end

endmodule : tb_reservation_unit
`default_nettype wire
